// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the transaction-layer TX arbiter:
//   fc_type_e   : flow-control class of a TLP (Posted / Non-Posted / Completion)
//   SRC_*       : arbiter source indices
//   state_e     : arbiter FSM states
//   data_need() : data credits a TLP consumes (one credit per 4 DW)
// ---------------------------------------------------------------------------
package tl_pkg;

    typedef enum logic [1:0] {
        FC_P   = 2'b00,
        FC_NP  = 2'b01,
        FC_CPL = 2'b10
    } fc_type_e;

    localparam int SRC_RX     = 0;
    localparam int SRC_MASTER = 1;
    localparam int SRC_SLAVE  = 2;
    localparam int NUM_SRC    = 3;
    localparam int NUM_FC     = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // ceil(len/4) with len==0 meaning 1024 DW; payload-less TLPs need nothing.
    function automatic logic [8:0] data_need(input logic has_data, input logic [9:0] len);
        logic [10:0] len_dw;
        logic [10:0] rounded;
        len_dw  = (len == 10'd0) ? 11'd1024 : {1'b0, len};
        rounded = (len_dw + 11'd3) >> 2;
        return has_data ? rounded[8:0] : 9'd0;
    endfunction

endpackage

// File: rtl/tl_fc_credit_check.sv
// ---------------------------------------------------------------------------
// tl_fc_credit_check
// Combinational flow-control gate for one credit class.
//   limit_i    : advertised credit limit (modular)
//   consumed_i : credits consumed so far (modular)
//   need_i     : credits this TLP would consume
//   inf_i      : receiver advertised infinite credits
//   ok_o       : TLP may be sent without exceeding the limit
// ---------------------------------------------------------------------------
module tl_fc_credit_check #(
    parameter int W = 12
) (
    input  logic [W-1:0] limit_i,
    input  logic [W-1:0] consumed_i,
    input  logic [W-1:0] need_i,
    input  logic         inf_i,
    output logic         ok_o
);

    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] headroom;

    // Counters are free-running modulo 2^W; a "negative" headroom shows up
    // as a value above half range.
    assign headroom = limit_i - (consumed_i + need_i);
    assign ok_o     = inf_i || (need_i == '0) || (headroom <= HALF);

endmodule

// File: rtl/tl_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tl_tx_arbiter
// Round-robin arbiter sharing the TL TX path between three TLP sources,
// gated by receiver flow-control credits; also owns the consumed counters.
//   i_clk / i_n_rst               : clock, asynchronous active-low reset
//   i_req_valid[2:0]              : per-source request (0 RX, 1 master, 2 slave)
//   i_req_fc_type[5:0]            : 2 bits per source (P/NP/CPL, 11 illegal)
//   i_req_has_data[2:0]           : per-source payload present
//   i_req_length[29:0]            : 10-bit DW length per source (0 = 1024)
//   i_fc_hdr/data_credit_limit_bus: per-type limits, [P|NP|CPL] from LSB
//   i_fc_hdr_inf / i_fc_data_inf  : per-type infinite credits
//   i_xfer_done                   : last beat of the granted TLP accepted
//   o_grant / o_busy              : registered one-hot grant, grant outstanding
//   o_fc_hdr/data_consumed_bus    : consumed credits per type
// ---------------------------------------------------------------------------
module tl_tx_arbiter
    import tl_pkg::*;
#(
    parameter int HDR_CREDS_WIDTH  = 12,
    parameter int DATA_CREDS_WIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_n_rst,
    input  logic [2:0]                    i_req_valid,
    input  logic [5:0]                    i_req_fc_type,
    input  logic [2:0]                    i_req_has_data,
    input  logic [29:0]                   i_req_length,
    input  logic [3*HDR_CREDS_WIDTH-1:0]  i_fc_hdr_credit_limit_bus,
    input  logic [3*DATA_CREDS_WIDTH-1:0] i_fc_data_credit_limit_bus,
    input  logic [2:0]                    i_fc_hdr_inf,
    input  logic [2:0]                    i_fc_data_inf,
    input  logic                          i_xfer_done,
    output logic [2:0]                    o_grant,
    output logic                          o_busy,
    output logic [3*HDR_CREDS_WIDTH-1:0]  o_fc_hdr_consumed_bus,
    output logic [3*DATA_CREDS_WIDTH-1:0] o_fc_data_consumed_bus
);

    localparam int HW = HDR_CREDS_WIDTH;
    localparam int DW = DATA_CREDS_WIDTH;

    // Registered state
    state_e        state_q;
    logic [2:0]    grant_q;
    logic [1:0]    last_q;
    logic [HW-1:0] hdr_cons_q  [NUM_FC];
    logic [DW-1:0] data_cons_q [NUM_FC];

    // Per-type limits unpacked from the buses
    logic [HW-1:0] hdr_lim  [NUM_FC];
    logic [DW-1:0] data_lim [NUM_FC];

    // Per-source decode
    logic [1:0]    src_tidx [NUM_SRC];
    logic [DW-1:0] src_need [NUM_SRC];
    logic [2:0]    src_legal;
    logic [2:0]    hdr_ok;
    logic [2:0]    data_ok;
    logic [2:0]    eligible;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FC; gi++) begin : g_type
            assign hdr_lim[gi]  = i_fc_hdr_credit_limit_bus[gi*HW +: HW];
            assign data_lim[gi] = i_fc_data_credit_limit_bus[gi*DW +: DW];
            assign o_fc_hdr_consumed_bus[gi*HW +: HW]  = hdr_cons_q[gi];
            assign o_fc_data_consumed_bus[gi*DW +: DW] = data_cons_q[gi];
        end

        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [1:0] raw_type;
            assign raw_type      = i_req_fc_type[2*gi +: 2];
            assign src_legal[gi] = (raw_type != 2'b11);
            // Illegal types are never eligible; steer them to a valid index
            // so the credit lookup never goes out of range.
            assign src_tidx[gi]  = src_legal[gi] ? raw_type : 2'd0;
            assign src_need[gi]  = DW'(data_need(i_req_has_data[gi], i_req_length[10*gi +: 10]));

            tl_fc_credit_check #(.W(HW)) u_hdr_chk (
                .limit_i    (hdr_lim[src_tidx[gi]]),
                .consumed_i (hdr_cons_q[src_tidx[gi]]),
                .need_i     (HW'(1)),
                .inf_i      (i_fc_hdr_inf[src_tidx[gi]]),
                .ok_o       (hdr_ok[gi])
            );

            tl_fc_credit_check #(.W(DW)) u_data_chk (
                .limit_i    (data_lim[src_tidx[gi]]),
                .consumed_i (data_cons_q[src_tidx[gi]]),
                .need_i     (src_need[gi]),
                .inf_i      (i_fc_data_inf[src_tidx[gi]]),
                .ok_o       (data_ok[gi])
            );

            assign eligible[gi] = i_req_valid[gi] && src_legal[gi] && hdr_ok[gi] && data_ok[gi];
        end
    endgenerate

    // Round-robin pick: start after the last winner, skip credit-blocked
    // sources so one stalled source never blocks the others.
    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] rr_start;

    always_comb begin
        logic [2:0] cand;
        win_found = 1'b0;
        win_idx   = 2'd0;
        rr_start  = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        cand      = 3'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, rr_start} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!win_found && eligible[cand[1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[1:0];
            end
        end
    end

    logic [1:0]    win_type;
    logic [DW-1:0] win_need;
    assign win_type = src_tidx[win_idx];
    assign win_need = src_need[win_idx];

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            last_q  <= 2'd2;
            for (int t = 0; t < NUM_FC; t++) begin
                hdr_cons_q[t]  <= '0;
                data_cons_q[t] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q              <= BUSY;
                        grant_q              <= 3'b001 << win_idx;
                        last_q               <= win_idx;
                        hdr_cons_q[win_type]  <= hdr_cons_q[win_type] + HW'(1);
                        data_cons_q[win_type] <= data_cons_q[win_type] + win_need;
                    end
                end
                BUSY: begin
                    // Completion wins over any new request this cycle; those
                    // are arbitrated in the following IDLE cycle.
                    if (i_xfer_done) begin
                        state_q <= IDLE;
                        grant_q <= 3'b000;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 3'b000;
                end
            endcase
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q == BUSY);

endmodule

// File: tb/tb_tl_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tl_tx_arbiter
// Directed, self-checking bench for tl_tx_arbiter.
// ---------------------------------------------------------------------------
module tb_tl_tx_arbiter;

    logic        i_clk;
    logic        i_n_rst;
    logic [2:0]  i_req_valid;
    logic [5:0]  i_req_fc_type;
    logic [2:0]  i_req_has_data;
    logic [29:0] i_req_length;
    logic [35:0] i_fc_hdr_credit_limit_bus;
    logic [47:0] i_fc_data_credit_limit_bus;
    logic [2:0]  i_fc_hdr_inf;
    logic [2:0]  i_fc_data_inf;
    logic        i_xfer_done;
    logic [2:0]  o_grant;
    logic        o_busy;
    logic [35:0] o_fc_hdr_consumed_bus;
    logic [47:0] o_fc_data_consumed_bus;

    logic [1:0]  typ     [3];
    logic [9:0]  len     [3];
    logic [11:0] hdr_lim [3];
    logic [15:0] dat_lim [3];

    assign i_req_fc_type              = {typ[2], typ[1], typ[0]};
    assign i_req_length               = {len[2], len[1], len[0]};
    assign i_fc_hdr_credit_limit_bus  = {hdr_lim[2], hdr_lim[1], hdr_lim[0]};
    assign i_fc_data_credit_limit_bus = {dat_lim[2], dat_lim[1], dat_lim[0]};

    int n_cmp;
    int n_fail;
    int grants;

    tl_tx_arbiter #(
        .HDR_CREDS_WIDTH  (12),
        .DATA_CREDS_WIDTH (16)
    ) dut (
        .i_clk                      (i_clk),
        .i_n_rst                    (i_n_rst),
        .i_req_valid                (i_req_valid),
        .i_req_fc_type              (i_req_fc_type),
        .i_req_has_data             (i_req_has_data),
        .i_req_length               (i_req_length),
        .i_fc_hdr_credit_limit_bus  (i_fc_hdr_credit_limit_bus),
        .i_fc_data_credit_limit_bus (i_fc_data_credit_limit_bus),
        .i_fc_hdr_inf               (i_fc_hdr_inf),
        .i_fc_data_inf              (i_fc_data_inf),
        .i_xfer_done                (i_xfer_done),
        .o_grant                    (o_grant),
        .o_busy                     (o_busy),
        .o_fc_hdr_consumed_bus      (o_fc_hdr_consumed_bus),
        .o_fc_data_consumed_bus     (o_fc_data_consumed_bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) begin
            $display("ok   %s obs=%0h exp=%0h", tag, obs, exp);
        end else begin
            n_fail++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset;
        i_n_rst     = 1'b0;
        i_xfer_done = 1'b0;
        tick();
        tick();
        i_n_rst = 1'b1;
    endtask

    // Grant expected on the next edge; held one more cycle; i_xfer_done at
    // the following edge drops it. clr removes sources from the request set.
    task automatic grant_cycle(input string tag, input logic [2:0] exp, input logic [2:0] clr);
        tick();
        chk({tag, "_grant"}, 64'(o_grant), 64'(exp));
        tick();
        chk({tag, "_hold"}, 64'(o_grant), 64'(exp));
        i_xfer_done = 1'b1;
        tick();
        i_xfer_done = 1'b0;
        chk({tag, "_drop"}, 64'({o_busy, o_grant}), 64'd0);
        i_req_valid = i_req_valid & ~clr;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        // ---- reset with a request pending ----
        i_n_rst        = 1'b0;
        i_xfer_done    = 1'b0;
        i_req_valid    = 3'b001;
        i_req_has_data = 3'b001;
        typ[0] = 2'b00; typ[1] = 2'b10; typ[2] = 2'b01;
        len[0] = 10'd8; len[1] = 10'd4; len[2] = 10'd4;
        hdr_lim[0] = 12'd10;  hdr_lim[1] = 12'd0; hdr_lim[2] = 12'd0;
        dat_lim[0] = 16'd100; dat_lim[1] = 16'd0; dat_lim[2] = 16'd0;
        i_fc_hdr_inf  = 3'b000;
        i_fc_data_inf = 3'b000;
        tick();
        tick();
        chk("rst_grant", 64'(o_grant), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_hdr", 64'(o_fc_hdr_consumed_bus), 64'd0);
        chk("rst_data", 64'(o_fc_data_consumed_bus), 64'd0);
        i_n_rst = 1'b1;
        tick();
        chk("first_grant", 64'(o_grant), 64'b001);
        chk("first_busy", 64'(o_busy), 64'd1);
        chk("first_p_hdr", 64'(o_fc_hdr_consumed_bus), 64'd1);
        chk("first_p_data", 64'(o_fc_data_consumed_bus), 64'd2);
        i_req_valid = 3'b000;
        i_xfer_done = 1'b1;
        tick();
        i_xfer_done = 1'b0;
        chk("first_drop", 64'(o_grant), 64'd0);

        // ---- round robin, infinite credits ----
        do_reset();
        i_fc_hdr_inf   = 3'b111;
        i_fc_data_inf  = 3'b111;
        typ[0] = 2'b00; typ[1] = 2'b10; typ[2] = 2'b01;
        len[0] = 10'd4;
        i_req_has_data = 3'b001;
        i_req_valid    = 3'b111;
        grant_cycle("rr0", 3'b001, 3'b000);
        grant_cycle("rr1", 3'b010, 3'b000);
        grant_cycle("rr2", 3'b100, 3'b000);
        grant_cycle("rr3", 3'b001, 3'b111);
        chk("rr_hdr", 64'(o_fc_hdr_consumed_bus), 64'({12'd1, 12'd1, 12'd2}));
        chk("rr_data", 64'(o_fc_data_consumed_bus), 64'({16'd0, 16'd0, 16'd2}));

        // ---- credit skip: NP blocked, CPL passes ----
        do_reset();
        i_fc_hdr_inf   = 3'b000;
        i_fc_data_inf  = 3'b000;
        i_req_has_data = 3'b000;
        hdr_lim[1] = 12'd0;   // NP
        hdr_lim[2] = 12'd5;   // CPL
        typ[1] = 2'b10; typ[2] = 2'b01;
        i_req_valid = 3'b110;
        grant_cycle("skip_cpl", 3'b010, 3'b010);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("skip_np_blocked", 64'(o_grant), 64'd0);
        end
        hdr_lim[1] = 12'd1;
        grant_cycle("skip_np_go", 3'b100, 3'b100);
        chk("skip_hdr", 64'(o_fc_hdr_consumed_bus), 64'({12'd1, 12'd1, 12'd0}));

        // ---- length 0 => 256 data credits ----
        do_reset();
        typ[1] = 2'b10;
        len[1] = 10'd0;
        i_req_has_data = 3'b010;
        hdr_lim[2] = 12'd10;
        dat_lim[2] = 16'd256;
        i_req_valid = 3'b010;
        grant_cycle("len0_256", 3'b010, 3'b010);
        chk("len0_data", 64'(o_fc_data_consumed_bus), 64'({16'd256, 16'd0, 16'd0}));
        do_reset();
        dat_lim[2] = 16'd255;
        i_req_valid = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("len0_255_blocked", 64'(o_grant), 64'd0);
        end
        chk("len0_255_data", 64'(o_fc_data_consumed_bus), 64'd0);
        i_req_valid = 3'b000;

        // ---- header counter wrap ----
        do_reset();
        typ[0] = 2'b00;
        i_req_has_data = 3'b000;
        i_fc_hdr_inf   = 3'b001;
        i_req_valid    = 3'b001;
        i_xfer_done    = 1'b1;
        grants = 0;
        for (int i = 0; i < 8189; i++) begin
            tick();
            if (o_grant == 3'b001) grants++;
        end
        i_req_valid = 3'b000;
        tick();
        i_xfer_done = 1'b0;
        chk("wrap_grants", 64'(grants), 64'd4095);
        chk("wrap_p_hdr_4095", 64'(o_fc_hdr_consumed_bus[11:0]), 64'd4095);
        i_fc_hdr_inf = 3'b000;
        hdr_lim[0]   = 12'd0;
        i_req_valid  = 3'b001;
        grant_cycle("wrap_go", 3'b001, 3'b001);
        chk("wrap_p_hdr_0", 64'(o_fc_hdr_consumed_bus[11:0]), 64'd0);

        // ---- reset during BUSY ----
        do_reset();
        i_fc_hdr_inf  = 3'b111;
        i_fc_data_inf = 3'b111;
        typ[1] = 2'b10;
        i_req_valid = 3'b010;
        tick();
        chk("mid_grant", 64'(o_grant), 64'b010);
        chk("mid_cpl_hdr", 64'(o_fc_hdr_consumed_bus), 64'({12'd1, 24'd0}));
        #3;
        i_n_rst = 1'b0;
        #1;
        chk("mid_async_grant", 64'({o_busy, o_grant}), 64'd0);
        chk("mid_async_hdr", 64'(o_fc_hdr_consumed_bus), 64'd0);
        chk("mid_async_data", 64'(o_fc_data_consumed_bus), 64'd0);
        i_req_valid = 3'b111;
        tick();
        tick();
        i_n_rst = 1'b1;
        tick();
        chk("mid_after_rst", 64'(o_grant), 64'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_tx_arbiter.md
# tl_tx_arbiter

Transaction-layer TX arbiter. Shares the single TL_TX output path between three TLP sources: RX-generated completions and error messages, AXI master bridge completions, and AXI slave bridge requests. It gates each source on receiver flow-control credits. It keeps the per-type consumed-credit counters, and it grants one source at a time, round-robin, holding the grant until that source's last beat is accepted.

## Interface
Parameters:
- HDR_CREDS_WIDTH, 12, header credit counter/limit width
- DATA_CREDS_WIDTH, 16, data credit counter/limit width

Ports:
- i_clk  in  1  clock
- i_n_rst  in  1  asynchronous active-low reset
- i_req_valid  in  3  per-source request; bit0 RX cpl/msg, bit1 master-bridge cpl, bit2 slave-bridge request
- i_req_fc_type  in  6  2 bits per source: 00 Posted, 01 Non-Posted, 10 Completion (11 illegal, never eligible)
- i_req_has_data  in  3  per-source: TLP carries payload
- i_req_length  in  30  10 bits per source: TLP Length field in DW (0 encodes 1024)
- i_fc_hdr_credit_limit_bus  in  3*HDR_CREDS_WIDTH  per-type header credit limit, [P|NP|CPL] from LSB
- i_fc_data_credit_limit_bus  in  3*DATA_CREDS_WIDTH  per-type data credit limit, same order
- i_fc_hdr_inf  in  3  per-type infinite header credits
- i_fc_data_inf  in  3  per-type infinite data credits
- i_xfer_done  in  1  last beat of granted TLP accepted downstream
- o_grant  out  3  one-hot registered grant
- o_busy  out  1  grant outstanding
- o_fc_hdr_consumed_bus  out  3*HDR_CREDS_WIDTH  header credits consumed, per type
- o_fc_data_consumed_bus  out  3*DATA_CREDS_WIDTH  data credits consumed, per type

## Operation
- Data credits needed (need_d): ceil(len/4) with len=0 treated as 1024, so the value is 256. It is 0 when has_data=0. Header credits needed: always 1.
- Eligibility per source: valid, fc_type legal, and both the header and data checks pass for that type.
  - Header check passes if inf, or if (limit − (consumed+1)) mod 2^HDR_CREDS_WIDTH ≤ 2^(HDR_CREDS_WIDTH−1).
  - Data check passes if inf, if need_d=0, or if (limit − (consumed+need_d)) mod 2^DATA_CREDS_WIDTH ≤ 2^(DATA_CREDS_WIDTH−1).
- All counter arithmetic is modulo its width. Counters wrap silently.
- Round-robin: search starts at (last_grant+1) mod 3. The first eligible source wins. An ineligible (credit-blocked) source is skipped, so there is no head-of-line blocking across sources. last_grant resets to 2, so source 0 is searched first after reset.
- FSM:
  - IDLE: if any source is eligible → BUSY. On that edge: o_grant = winner, last_grant = winner, hdr_consumed[type] += 1, data_consumed[type] += need_d.
  - BUSY: hold o_grant. On i_xfer_done → IDLE and o_grant = 0.
- Source contract: valid and attributes stay stable from assertion until grant. Changes to valid while granted are ignored. Only i_xfer_done ends a grant.
- i_xfer_done in IDLE is ignored.
- Limit changes take effect in the next IDLE evaluation. A grant already issued is never revoked.

## Timing
- Reset values: o_grant=0, o_busy=0, all consumed counters=0, state IDLE, last_grant=2.
- Eligible request sampled in IDLE at edge N → o_grant/o_busy high after edge N, and counters updated at edge N.
- i_xfer_done high at edge M → o_grant/o_busy low after M. The next grant comes no earlier than edge M+1, leaving a one-cycle minimum gap.
- Reset asserted mid-transfer: grant drops immediately (asynchronous) and counters clear. The partial TLP is the downstream's responsibility.
- Simultaneous i_xfer_done and new requests in BUSY: complete first. The new requests are arbitrated in the following IDLE cycle.

## Structure
- Shared package tl_pkg:
  - fc_type_e enum (FC_P=2'b00, FC_NP=2'b01, FC_CPL=2'b10)
  - source index constants SRC_RX=0, SRC_MASTER=1, SRC_SLAVE=2
  - state enum {IDLE, BUSY}
- One sub-module: tl_fc_credit_check. It is combinational and takes limit, consumed, need, inf and width parameter, returning ok. Instantiate it 3 sources × {hdr, data}.
- Consumed counters and the FSM live in the top module.

## Test plan
- Reset: hold i_n_rst low with requests driven → o_grant=0, o_busy=0, all consumed=0. Release; source 0 is valid (Posted, len=8), credits sufficient → o_grant=3'b001 one cycle later, P hdr consumed=1, P data consumed=2.
- Round-robin: all three valid with infinite credits, i_xfer_done pulsed two cycles after each grant → grant order 001, 010, 100, 001, one idle cycle between grants.
- Credit skip: NP hdr limit=0, consumed=0, source 2 NP valid, source 1 CPL valid → source 1 granted and source 2 never granted. Raise NP limit to 1 → source 2 granted next IDLE.
- Length 0: source 1 CPL with has_data=1, len=0, data limit=256 → granted, CPL data consumed=256. Repeat with limit=255 → blocked.
- Wrap: P hdr consumed=4095, limit=0 → eligible; after grant, consumed=0.
- Reset mid-BUSY: assert i_n_rst while o_grant=3'b010 → o_grant=0 before the next edge and counters=0. After release, source 0 wins first.
